discriminator_seq: RTL

//  Time-multiplexed successor of the combinational discriminator: a 2-layer fixed-point MLP with N_INPUT inputs,
//  N_HIDDEN ReLU hidden neurons and one linear output neuron. It computes on one shared MAC over many cycles.

---
 rtl/discriminator_seq_pkg.sv | 26 ++
 rtl/discriminator_seq_mac.sv | 38 +++
 rtl/discriminator_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/discriminator_seq_pkg.sv
// Shared types and sizing helpers for the sequential fixed-point NN blocks.
package discriminator_seq_pkg;

  localparam int FRAC_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L2_MAC,
    ST_L2_ACT,
    ST_L3_MAC,
    ST_L3_ACT,
    ST_DONE
  } state_t;

  // Accumulator sized for the longest dot product plus the shifted bias term.
  function automatic int acc_width(input int width, input int n_input, input int n_hidden);
    int n_max;
    n_max = (n_input > n_hidden) ? n_input : n_hidden;
    return 2 * width + $clog2(n_max + 1) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/discriminator_seq_mac.sv
// Signed multiply-accumulate: full-width product, load/clear/enable on a wide accumulator.
module discriminator_seq_mac
  import discriminator_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ACC_W = 69
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] w,
  input  logic signed [ACC_W-1:0] init,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_reg;

  assign prod     = a * w;
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_reg <= '0;
    end else if (load) begin
      acc_reg <= init + prod_ext;
    end else if (en) begin
      acc_reg <= acc_reg + prod_ext;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/discriminator_seq.sv
// Time-multiplexed 2-layer MLP discriminator (ReLU hidden layer, linear output) on one shared MAC.
module discriminator_seq
  import discriminator_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = FRAC_DEFAULT,
  parameter int N_INPUT  = 9,
  parameter int N_HIDDEN = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUT*WIDTH-1:0]       a_in,
  input  logic [N_INPUT*N_HIDDEN*WIDTH-1:0] w_L2,
  input  logic [N_HIDDEN*WIDTH-1:0]      b_L2,
  input  logic [N_HIDDEN*WIDTH-1:0]      w_L3,
  input  logic [WIDTH-1:0]               b_L3,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               y,
  output logic                           busy
);

  localparam int ACC_W = acc_width(WIDTH, N_INPUT, N_HIDDEN);
  localparam int K_N   = (N_INPUT > N_HIDDEN) ? N_INPUT : N_HIDDEN;
  localparam int K_W   = idx_width(K_N);
  localparam int J_W   = idx_width(N_HIDDEN);

  localparam logic signed [ACC_W-1:0] RND_CONST = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN   = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = (v + RND_CONST) >>> FRAC;
    if (r > SAT_MAX)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (r < SAT_MIN) return {1'b1, {(WIDTH-1){1'b0}}};
    else                  return r[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? '0 : x;
  endfunction

  function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [WIDTH-1:0] b);
    logic signed [ACC_W-1:0] e;
    e = {{(ACC_W-WIDTH){b[WIDTH-1]}}, b};
    return e <<< FRAC;
  endfunction

  logic signed [WIDTH-1:0] a_in_arr [N_INPUT];
  logic signed [WIDTH-1:0] w_l2_arr [N_HIDDEN*N_INPUT];
  logic signed [WIDTH-1:0] b_l2_arr [N_HIDDEN];
  logic signed [WIDTH-1:0] w_l3_arr [N_HIDDEN];

  for (genvar gi = 0; gi < N_INPUT; gi++) begin : g_a_unpack
    assign a_in_arr[gi] = a_in[(gi+1)*WIDTH-1 -: WIDTH];
  end
  for (genvar gi = 0; gi < N_HIDDEN*N_INPUT; gi++) begin : g_w2_unpack
    assign w_l2_arr[gi] = w_L2[(gi+1)*WIDTH-1 -: WIDTH];
  end
  for (genvar gi = 0; gi < N_HIDDEN; gi++) begin : g_l3_unpack
    assign b_l2_arr[gi] = b_L2[(gi+1)*WIDTH-1 -: WIDTH];
    assign w_l3_arr[gi] = w_L3[(gi+1)*WIDTH-1 -: WIDTH];
  end

  state_t                  state_reg, state_next;
  logic [K_W-1:0]          k_reg;
  logic [J_W-1:0]          j_reg;
  logic signed [WIDTH-1:0] a_reg [N_INPUT];
  logic signed [WIDTH-1:0] h_reg [N_HIDDEN];
  logic signed [WIDTH-1:0] y_reg;

  logic                    accept;
  logic                    mac_clear, mac_load, mac_en;
  logic signed [WIDTH-1:0] mac_a, mac_w;
  logic signed [ACC_W-1:0] mac_init, mac_acc;
  logic signed [WIDTH-1:0] act_val;

  assign accept  = in_valid && in_ready;
  assign act_val = round_sat(mac_acc);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (in_valid) state_next = ST_L2_MAC;
      ST_L2_MAC: if (k_reg == K_W'(N_INPUT-1)) state_next = ST_L2_ACT;
      ST_L2_ACT: state_next = (j_reg == J_W'(N_HIDDEN-1)) ? ST_L3_MAC : ST_L2_MAC;
      ST_L3_MAC: if (k_reg == K_W'(N_HIDDEN-1)) state_next = ST_L3_ACT;
      ST_L3_ACT: state_next = ST_DONE;
      ST_DONE:   if (out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    busy      = (state_reg != ST_IDLE);
    out_valid = (state_reg == ST_DONE);
    mac_clear = (state_reg == ST_IDLE);
    mac_load  = 1'b0;
    mac_en    = 1'b0;
    if (state_reg == ST_L2_MAC || state_reg == ST_L3_MAC) begin
      mac_load = (k_reg == '0);
      mac_en   = (k_reg != '0);
    end
  end

  // Operand muxes: layer 2 reads latched inputs, layer 3 reads the hidden register file.
  always_comb begin
    mac_a    = '0;
    mac_w    = '0;
    mac_init = '0;
    if (state_reg == ST_L2_MAC) begin
      for (int i = 0; i < N_INPUT; i++) begin
        if (k_reg == K_W'(i)) mac_a = a_reg[i];
      end
      for (int jj = 0; jj < N_HIDDEN; jj++) begin
        if (j_reg == J_W'(jj)) mac_init = bias_ext(b_l2_arr[jj]);
        for (int i = 0; i < N_INPUT; i++) begin
          if (j_reg == J_W'(jj) && k_reg == K_W'(i)) mac_w = w_l2_arr[N_INPUT*jj+i];
        end
      end
    end else if (state_reg == ST_L3_MAC) begin
      mac_init = bias_ext(b_L3);
      for (int i = 0; i < N_HIDDEN; i++) begin
        if (k_reg == K_W'(i)) begin
          mac_a = h_reg[i];
          mac_w = w_l3_arr[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg <= '0;
      j_reg <= '0;
    end else begin
      case (state_reg)
        ST_L2_MAC: k_reg <= (k_reg == K_W'(N_INPUT-1)) ? '0 : k_reg + K_W'(1);
        ST_L2_ACT: j_reg <= (j_reg == J_W'(N_HIDDEN-1)) ? '0 : j_reg + J_W'(1);
        ST_L3_MAC: k_reg <= (k_reg == K_W'(N_HIDDEN-1)) ? '0 : k_reg + K_W'(1);
        ST_IDLE: begin
          k_reg <= '0;
          j_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_INPUT; i++) a_reg[i] <= '0;
      for (int i = 0; i < N_HIDDEN; i++) h_reg[i] <= '0;
      y_reg <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_INPUT; i++) a_reg[i] <= a_in_arr[i];
      end
      if (state_reg == ST_L2_ACT) begin
        for (int i = 0; i < N_HIDDEN; i++) begin
          if (j_reg == J_W'(i)) h_reg[i] <= relu(act_val);
        end
      end
      // y persists through IDLE so a late reader still sees the last score.
      if (state_reg == ST_L3_ACT) y_reg <= act_val;
    end
  end

  assign y = y_reg;

  discriminator_seq_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .load  (mac_load),
    .en    (mac_en),
    .a     (mac_a),
    .w     (mac_w),
    .init  (mac_init),
    .acc   (mac_acc)
  );

endmodule
